// File: rtl/bp_cache_2r1w_pkg.sv
// Shared constants and helpers for the branch-predictor lookup cache.
// Default geometry matches the BTB / history-table instance in the predictor.
package bp_cache_2r1w_pkg;

    localparam int DEF_AWIDTH = 32;
    localparam int DEF_DWIDTH = 32;
    localparam int DEF_LINES  = 128;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_cache_2r1w_if.sv
// Port bundle for the 2-read/1-write cache: two lookup ports plus one write port.
// The write port has no handshake: a line is installed on every rising clk edge where we=1.
interface bp_cache_2r1w_if
    import bp_cache_2r1w_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH
);
    logic [AWIDTH-1:0] ra0;
    logic [AWIDTH-1:0] ra1;
    logic [AWIDTH-1:0] wa;
    logic [DWIDTH-1:0] din;
    logic              we;
    logic [DWIDTH-1:0] dout0;
    logic [DWIDTH-1:0] dout1;
    logic              hit0;
    logic              hit1;

    modport master (
        output ra0, ra1, wa, din, we,
        input  dout0, dout1, hit0, hit1
    );

    modport slave (
        input  ra0, ra1, wa, din, we,
        output dout0, dout1, hit0, hit1
    );
endinterface

// File: rtl/bp_cache_2r1w_lookup.sv
// One combinational lookup port: index/tag split, valid-and-tag compare, data mux.
// Data is driven on a miss too, so callers see whatever line sits at the index.
module bp_cache_lookup
    import bp_cache_2r1w_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int LINES  = DEF_LINES,
    parameter int IBITS  = clog2(LINES),
    parameter int TBITS  = AWIDTH - IBITS
) (
    input  logic [AWIDTH-1:0] addr,
    input  logic [LINES-1:0]  valid,
    input  logic [TBITS-1:0]  tags [LINES],
    input  logic [DWIDTH-1:0] data [LINES],
    output logic [DWIDTH-1:0] dout,
    output logic              hit
);
    logic [IBITS-1:0] index;
    logic [TBITS-1:0] tag;

    always_comb begin
        index = addr[IBITS-1:0];
        tag   = addr[AWIDTH-1:IBITS];
        dout  = data[index];
        hit   = valid[index] && (tags[index] == tag);
    end
endmodule

// File: rtl/bp_cache_2r1w.sv
// Direct-mapped tagged cache, two combinational read ports and one write port.
// Storage is in flops so the whole array clears on asynchronous reset.
module bp_cache_2r1w
    import bp_cache_2r1w_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int LINES  = DEF_LINES
) (
    input  logic           clk,
    input  logic           reset,
    bp_cache_2r1w_if.slave bus
);
    localparam int IBITS = clog2(LINES);
    localparam int TBITS = AWIDTH - IBITS;

    logic [LINES-1:0]  valid;
    logic [TBITS-1:0]  tags [LINES];
    logic [DWIDTH-1:0] data [LINES];

    logic [IBITS-1:0]  w_index;
    logic [TBITS-1:0]  w_tag;

    always_comb begin
        w_index = bus.wa[IBITS-1:0];
        w_tag   = bus.wa[AWIDTH-1:IBITS];
    end

    // Writes always allocate: a hit updates in place, a conflict evicts the old tag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < LINES; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else if (bus.we) begin
            valid[w_index] <= 1'b1;
            tags[w_index]  <= w_tag;
            data[w_index]  <= bus.din;
        end
    end

    bp_cache_lookup #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH),
        .LINES (LINES)
    ) u_lookup0 (
        .addr (bus.ra0),
        .valid(valid),
        .tags (tags),
        .data (data),
        .dout (bus.dout0),
        .hit  (bus.hit0)
    );

    bp_cache_lookup #(
        .AWIDTH(AWIDTH),
        .DWIDTH(DWIDTH),
        .LINES (LINES)
    ) u_lookup1 (
        .addr (bus.ra1),
        .valid(valid),
        .tags (tags),
        .data (data),
        .dout (bus.dout1),
        .hit  (bus.hit1)
    );
endmodule

// File: tb/tb_bp_cache_2r1w.sv
// Directed bench for bp_cache_2r1w (LINES=128): fill, hit, evict, dual-port, same-cycle and reset cases.
module tb_bp_cache_2r1w;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    bp_cache_2r1w_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    bp_cache_2r1w #(.AWIDTH(32), .DWIDTH(32), .LINES(128)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.wa  = a;
        bus.din = d;
        bus.we  = 1'b1;
        @(posedge clk);
        #1;
        bus.we  = 1'b0;
    endtask

    task automatic test_reset();
        bus.ra0 = 32'h0;
        bus.ra1 = 32'h0;
        bus.wa  = 32'h0;
        bus.din = 32'h0;
        bus.we  = 1'b0;
        reset   = 1'b0;
        #2;
        reset   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset   = 1'b0;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b0) begin n_fail++; $display("FAIL reset_hit0 got %b exp 0", bus.hit0); end
        n_checks++;
        if (bus.hit1 !== 1'b0) begin n_fail++; $display("FAIL reset_hit1 got %b exp 0", bus.hit1); end
        n_checks++;
        if (bus.dout0 !== 32'h0) begin n_fail++; $display("FAIL reset_dout0 got %h exp 0", bus.dout0); end
        n_checks++;
        if (bus.dout1 !== 32'h0) begin n_fail++; $display("FAIL reset_dout1 got %h exp 0", bus.dout1); end
    endtask

    task automatic test_write_hit();
        do_write(32'h0000_0011, 32'd3);
        bus.ra0 = 32'h0000_0011;
        bus.ra1 = 32'h0000_0011;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'd3) begin
            n_fail++; $display("FAIL fill_p0 got hit=%b dout=%h exp hit=1 dout=3", bus.hit0, bus.dout0);
        end
        n_checks++;
        if (bus.hit1 !== 1'b1 || bus.dout1 !== 32'd3) begin
            n_fail++; $display("FAIL fill_p1 got hit=%b dout=%h exp hit=1 dout=3", bus.hit1, bus.dout1);
        end
        do_write(32'h0000_0011, 32'd2);
        #1;
        n_checks++;
        if (bus.hit1 !== 1'b1 || bus.dout1 !== 32'd2) begin
            n_fail++; $display("FAIL overwrite_p1 got hit=%b dout=%h exp hit=1 dout=2", bus.hit1, bus.dout1);
        end
        bus.ra0 = 32'h0000_0012;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b0 || bus.dout0 !== 32'd0) begin
            n_fail++; $display("FAIL empty_idx_p0 got hit=%b dout=%h exp hit=0 dout=0", bus.hit0, bus.dout0);
        end
    endtask

    task automatic test_conflict();
        do_write(32'h1100_0011, 32'd2);
        bus.ra1 = 32'h0000_0011;
        #1;
        n_checks++;
        if (bus.hit1 !== 1'b0 || bus.dout1 !== 32'd2) begin
            n_fail++; $display("FAIL evicted_p1 got hit=%b dout=%h exp hit=0 dout=2", bus.hit1, bus.dout1);
        end
        bus.ra0 = 32'h1100_0011;
        bus.ra1 = 32'h1100_0011;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'd2) begin
            n_fail++; $display("FAIL new_tag_p0 got hit=%b dout=%h exp hit=1 dout=2", bus.hit0, bus.dout0);
        end
        n_checks++;
        if (bus.hit1 !== 1'b1 || bus.dout1 !== 32'd2) begin
            n_fail++; $display("FAIL new_tag_p1 got hit=%b dout=%h exp hit=1 dout=2", bus.hit1, bus.dout1);
        end
    endtask

    task automatic test_independent_ports();
        do_write(32'h0000_0100, 32'd3);
        bus.ra0 = 32'h0000_0100;
        bus.ra1 = 32'h1100_0011;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'd3) begin
            n_fail++; $display("FAIL indep_p0 got hit=%b dout=%h exp hit=1 dout=3", bus.hit0, bus.dout0);
        end
        n_checks++;
        if (bus.hit1 !== 1'b1 || bus.dout1 !== 32'd2) begin
            n_fail++; $display("FAIL indep_p1 got hit=%b dout=%h exp hit=1 dout=2", bus.hit1, bus.dout1);
        end
        bus.ra1 = 32'h0000_0011;
        #1;
        n_checks++;
        if (bus.hit1 !== 1'b0 || bus.dout1 !== 32'd2) begin
            n_fail++; $display("FAIL split_p1 got hit=%b dout=%h exp hit=0 dout=2", bus.hit1, bus.dout1);
        end
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'd3) begin
            n_fail++; $display("FAIL split_p0 got hit=%b dout=%h exp hit=1 dout=3", bus.hit0, bus.dout0);
        end
    endtask

    task automatic test_same_cycle();
        // 0x11001111 maps to index 0x11, currently holding tag of 0x11000011 with data 2
        bus.wa  = 32'h1100_1111;
        bus.ra0 = 32'h1100_1111;
        bus.din = 32'd2;
        bus.we  = 1'b1;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b0 || bus.dout0 !== 32'd2) begin
            n_fail++; $display("FAIL pre_edge_p0 got hit=%b dout=%h exp hit=0 dout=2", bus.hit0, bus.dout0);
        end
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'd2) begin
            n_fail++; $display("FAIL post_edge_p0 got hit=%b dout=%h exp hit=1 dout=2", bus.hit0, bus.dout0);
        end
        bus.ra0 = 32'h0000_0011;
        bus.ra1 = 32'h1111_0011;
        do_write(32'h1111_0011, 32'd0);
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b0 || bus.dout0 !== 32'd0) begin
            n_fail++; $display("FAIL zero_wr_p0 got hit=%b dout=%h exp hit=0 dout=0", bus.hit0, bus.dout0);
        end
        n_checks++;
        if (bus.hit1 !== 1'b1 || bus.dout1 !== 32'd0) begin
            n_fail++; $display("FAIL zero_wr_p1 got hit=%b dout=%h exp hit=1 dout=0", bus.hit1, bus.dout1);
        end
    endtask

    task automatic test_back_to_back();
        do_write(32'h0000_0005, 32'h0000_00aa);
        do_write(32'hffff_ff86, 32'h5555_0000);
        bus.ra0 = 32'h0000_0005;
        bus.ra1 = 32'hffff_ff86;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'h0000_00aa) begin
            n_fail++; $display("FAIL b2b_p0 got hit=%b dout=%h exp hit=1 dout=000000aa", bus.hit0, bus.dout0);
        end
        n_checks++;
        if (bus.hit1 !== 1'b1 || bus.dout1 !== 32'h5555_0000) begin
            n_fail++; $display("FAIL b2b_p1 got hit=%b dout=%h exp hit=1 dout=55550000", bus.hit1, bus.dout1);
        end
        bus.ra1 = 32'h0000_0006;
        #1;
        n_checks++;
        if (bus.hit1 !== 1'b0 || bus.dout1 !== 32'h5555_0000) begin
            n_fail++; $display("FAIL b2b_tag_p1 got hit=%b dout=%h exp hit=0 dout=55550000", bus.hit1, bus.dout1);
        end
    endtask

    task automatic test_reset_mid_run();
        bus.ra0 = 32'h0000_0100;
        bus.ra1 = 32'h1111_0011;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'd3) begin
            n_fail++; $display("FAIL pre_rst_p0 got hit=%b dout=%h exp hit=1 dout=3", bus.hit0, bus.dout0);
        end
        @(negedge clk);
        bus.wa  = 32'h0000_0100;
        bus.din = 32'h0000_0077;
        bus.we  = 1'b1;
        reset   = 1'b1;
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b0 || bus.dout0 !== 32'd0) begin
            n_fail++; $display("FAIL async_rst_p0 got hit=%b dout=%h exp hit=0 dout=0", bus.hit0, bus.dout0);
        end
        n_checks++;
        if (bus.hit1 !== 1'b0 || bus.dout1 !== 32'd0) begin
            n_fail++; $display("FAIL async_rst_p1 got hit=%b dout=%h exp hit=0 dout=0", bus.hit1, bus.dout1);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b0 || bus.dout0 !== 32'd0) begin
            n_fail++; $display("FAIL rst_blocks_wr got hit=%b dout=%h exp hit=0 dout=0", bus.hit0, bus.dout0);
        end
        @(negedge clk);
        bus.we = 1'b0;
        reset  = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b0 || bus.dout0 !== 32'd0) begin
            n_fail++; $display("FAIL post_rst_p0 got hit=%b dout=%h exp hit=0 dout=0", bus.hit0, bus.dout0);
        end
        do_write(32'h0000_0100, 32'h0000_0009);
        #1;
        n_checks++;
        if (bus.hit0 !== 1'b1 || bus.dout0 !== 32'h0000_0009) begin
            n_fail++; $display("FAIL refill_p0 got hit=%b dout=%h exp hit=1 dout=9", bus.hit0, bus.dout0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_hit();
        test_conflict();
        test_independent_ports();
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_cache_2r1w.md
Name: bp_cache_2r1w

Overview:
- Direct-mapped, tagged lookup cache with two independent combinational read ports and one synchronous write port.
- Used as the branch-predictor storage array, e.g. a BTB or history table: port 0 and port 1 serve two concurrent lookups (such as fetch and execute); the write port installs or updates entries.
- Each line holds a valid bit, a tag and a DWIDTH data word.
- A write always allocates, evicting whatever line occupied that index.

Parameters:
- AWIDTH, 32, lookup address width in bits.
- DWIDTH, 32, data word width in bits.
- LINES, 128, number of lines; power of two, at least 2. IBITS = clog2(LINES); TBITS = AWIDTH - IBITS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all lines.
- ra0  input  AWIDTH  read address, port 0.
- ra1  input  AWIDTH  read address, port 1.
- wa  input  AWIDTH  write address.
- din  input  DWIDTH  write data.
- we  input  1  write enable.
- dout0  output  DWIDTH  data stored at index of ra0.
- dout1  output  DWIDTH  data stored at index of ra1.
- hit0  output  1  ra0 lookup hit.
- hit1  output  1  ra1 lookup hit.

Behaviour:
- Address split, with no byte-offset bits dropped:
  - index = addr[IBITS-1:0]
  - tag = addr[AWIDTH-1:IBITS]
  - Example with LINES=128: 0x00000011 and 0x11000011 share index 0x11 with different tags; 0x00000012 is index 0x12.
- Storage per line: valid (1), tag (TBITS), data (DWIDTH). Implemented as flops so the array can be cleared asynchronously.
- Reset: while reset=1, and asynchronously on its assertion, all valid, tag and data bits go to 0. Hence hit0=hit1=0 and dout0=dout1=0 during reset and immediately after it, until a write.
- Reads are purely combinational, zero latency:
  - doutN = data[index(raN)], driven whether or not the lookup hits; on a miss it carries the evicting line's data.
  - hitN = valid[index(raN)] AND (tag[index(raN)] == tag(raN)).
- Writes: on rising clk with we=1 and reset=0, line index(wa) gets valid=1, tag=tag(wa), data=din.
  - The write is unconditional: it overwrites a hit in place or evicts the old tag on a conflict.
  - we=0 leaves the array unchanged.
- Read/write same cycle: a read sees the pre-edge contents (no combinational bypass from din). After the edge, the read ports show the new contents. Any number of ports may target the same index simultaneously.
- Both read ports are fully independent; a hit on one port and a miss on the other in the same cycle is legal.
- Reset has priority over a write on the same edge.

Decomposition:
- Shared package: a clog2 function, and the default AWIDTH/DWIDTH/LINES constants used by the branch predictor.
- Optional sub-module bp_cache_lookup: combinational index/tag extraction, valid AND tag-compare, and data mux. Instantiated once per read port. The array and write logic stay in the top.

Test Plan:
1. Assert reset 10 cycles, release; ra0=ra1=0x00000000 -> hit0=0, hit1=0.
2. Write miss, then hit:
   - we=1, wa=0x00000011, din=3 for one edge; then we=0, ra0=ra1=0x00000011 -> dout=3, hit=1.
   - Overwrite with din=2, then read 0x00000011 -> dout1=2, hit1=1.
   - ra0=0x00000012 -> hit0=0.
3. Conflict eviction:
   - Write wa=0x11000011, din=2.
   - ra1=0x00000011 -> hit1=0, dout1=2.
   - ra0=ra1=0x11000011 -> both hit=1, dout=2.
4. Independent ports:
   - Write wa=0x00000100, din=3.
   - ra0=0x00000100, ra1=0x11000011 -> hit0=hit1=1, dout0=3, dout1=2.
   - ra1=0x00000011 -> hit1=0, dout1=2, while port 0 still hits.
5. Same-cycle read and write:
   - we=1, wa=ra0=0x11001111, din=2. Before the edge: hit0=0, dout0 holds old data. After the edge: hit0=1, dout0=2.
   - Then we=1, wa=0x11110011, din=0, ra0=0x00000011, ra1=0x11110011. After the edge: dout0=dout1=0, hit0=0, hit1=1.
6. Reset mid-run:
   - Pulse reset asynchronously, between clock edges.
   - Outputs clear immediately: hit0=hit1=0, dout=0 for ra0=0x00000100, ra1=0x11110011.
   - With we=1 held during reset, no write occurs.
